// File: rtl/rr_grant_pkg.sv
// Shared types and constants for the 4-requester round-robin grant encoder.
package rr_grant_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDX_W = 2;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Previous owner after reset; makes requester 0 the first one searched.
  localparam idx_t RESET_LAST = 2'd3;

endpackage

// File: rtl/rr_grant_enc4_if.sv
// Request/grant bundle between the requesters and the round-robin encoder.
interface rr_grant_enc4_if;
  import rr_grant_pkg::*;

  logic [NREQ-1:0] req;
  logic            done;
  idx_t            gnt_idx;
  logic            gnt_valid;
  logic            timeout;
  logic            busy;

  modport master (
    output req, done,
    input  gnt_idx, gnt_valid, timeout, busy
  );

  modport slave (
    input  req, done,
    output gnt_idx, gnt_valid, timeout, busy
  );

endinterface

// File: rtl/rr_grant_enc4_pick4.sv
// Rotating-priority search: first set request after 'last', wrapping modulo 4.
module rr_pick4
  import rr_grant_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  idx_t            last,
  output idx_t            idx,
  output logic            any
);

  logic found;
  idx_t cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // Offset NREQ wraps back onto 'last', so the previous owner is tried last.
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = last + idx_t'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_grant_enc4.sv
// Round-robin arbiter for 4 requesters with registered binary grant index,
// grant hold/release control and a hold-limit timeout.
module rr_grant_enc4
  import rr_grant_pkg::*;
#(
  parameter  int unsigned MAX_HOLD = 16,
  localparam int unsigned CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input logic            clk,
  input logic            rst,
  rr_grant_enc4_if.slave bus
);

  state_t           state;
  idx_t             last;
  idx_t             gnt_idx_q;
  logic             timeout_q;
  logic [CNT_W-1:0] hold_cnt;

  idx_t pick_last;
  idx_t pick_idx;
  logic pick_any;
  logic owner_req;
  logic at_limit;
  logic release_now;
  logic force_rel;

  // While granting, the current owner becomes 'last' for same-edge re-arbitration.
  assign pick_last = (state == GRANT) ? gnt_idx_q : last;

  rr_pick4 u_pick (
    .req  (bus.req),
    .last (pick_last),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign owner_req   = bus.req[gnt_idx_q];
  assign at_limit    = (hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign release_now = (state == GRANT) && (bus.done || !owner_req || at_limit);
  assign force_rel   = (state == GRANT) && !bus.done && owner_req && at_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= RESET_LAST;
      gnt_idx_q <= '0;
      timeout_q <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      timeout_q <= force_rel;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state     <= GRANT;
            gnt_idx_q <= pick_idx;
            hold_cnt  <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            last     <= gnt_idx_q;
            hold_cnt <= '0;
            if (pick_any) begin
              gnt_idx_q <= pick_idx;
            end else begin
              state <= IDLE;
            end
          end else if (hold_cnt != CNT_W'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = (state == GRANT);
  assign bus.busy      = (state == GRANT);
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_enc4.sv
// Self-checking bench: four arbiters with different hold limits share one
// stimulus stream and are checked against a per-instance reference model.
module tb_rr_grant_enc4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;

  int n_cmp;
  int n_bad;

  rr_grant_enc4_if if0 ();
  rr_grant_enc4_if if1 ();
  rr_grant_enc4_if if2 ();
  rr_grant_enc4_if if3 ();

  assign if0.req = req;  assign if0.done = done;
  assign if1.req = req;  assign if1.done = done;
  assign if2.req = req;  assign if2.done = done;
  assign if3.req = req;  assign if3.done = done;

  rr_grant_enc4 #(.MAX_HOLD(16)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  rr_grant_enc4 #(.MAX_HOLD(4))  dut1 (.clk(clk), .rst(rst), .bus(if1));
  rr_grant_enc4 #(.MAX_HOLD(2))  dut2 (.clk(clk), .rst(rst), .bus(if2));
  rr_grant_enc4 #(.MAX_HOLD(1))  dut3 (.clk(clk), .rst(rst), .bus(if3));

  logic [1:0] d_idx   [4];
  logic       d_valid [4];
  logic       d_to    [4];
  logic       d_busy  [4];

  assign d_idx[0] = if0.gnt_idx; assign d_valid[0] = if0.gnt_valid; assign d_to[0] = if0.timeout; assign d_busy[0] = if0.busy;
  assign d_idx[1] = if1.gnt_idx; assign d_valid[1] = if1.gnt_valid; assign d_to[1] = if1.timeout; assign d_busy[1] = if1.busy;
  assign d_idx[2] = if2.gnt_idx; assign d_valid[2] = if2.gnt_valid; assign d_to[2] = if2.timeout; assign d_busy[2] = if2.busy;
  assign d_idx[3] = if3.gnt_idx; assign d_valid[3] = if3.gnt_valid; assign d_to[3] = if3.timeout; assign d_busy[3] = if3.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: m_held counts cycles the current owner has been visible.
  bit          m_valid [4];
  logic [1:0]  m_idx   [4];
  int unsigned m_last  [4];
  int unsigned m_held  [4];
  bit          m_to    [4];

  function automatic int unsigned hold_limit(input int k);
    case (k)
      0: return 16;
      1: return 4;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int unsigned ref_pick(input logic [3:0] r, input int unsigned last);
    for (int unsigned i = 1; i <= 4; i++) begin
      if (r[(last + i) % 4]) return (last + i) % 4;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_valid[k] = 0;
      m_idx[k]   = 2'd0;
      m_last[k]  = 3;
      m_held[k]  = 0;
      m_to[k]    = 0;
    end
  endtask

  task automatic model_step(input logic r, input logic [3:0] q, input logic d);
    bit owner_wants;
    bit rel;
    if (r) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 4; k++) begin
      m_to[k] = 0;
      if (!m_valid[k]) begin
        if (q != 4'd0) begin
          m_idx[k]   = 2'(ref_pick(q, m_last[k]));
          m_valid[k] = 1;
          m_held[k]  = 1;
        end
      end else begin
        owner_wants = q[m_idx[k]];
        rel = d || !owner_wants || (m_held[k] == hold_limit(k));
        if (rel) begin
          m_to[k]   = !d && owner_wants;
          m_last[k] = m_idx[k];
          if (q != 4'd0) begin
            m_idx[k]  = 2'(ref_pick(q, m_last[k]));
            m_held[k] = 1;
          end else begin
            m_valid[k] = 0;
            m_held[k]  = 0;
          end
        end else begin
          m_held[k] = m_held[k] + 1;
        end
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [3:0] dec;
    logic [3:0] exp_dec;
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("valid%0d", k), 32'(d_valid[k]), 32'(m_valid[k]));
      check_val($sformatf("idx%0d", k),   32'(d_idx[k]),   32'(m_idx[k]));
      check_val($sformatf("to%0d", k),    32'(d_to[k]),    32'(m_to[k]));
      check_val($sformatf("busy%0d", k),  32'(d_busy[k]),  32'(m_valid[k]));
    end
    // Downstream 2-to-4 decoder, qualified by gnt_valid.
    dec     = d_valid[0] ? (4'b0001 << d_idx[0]) : 4'b0000;
    exp_dec = m_valid[0] ? (4'b0001 << m_idx[0]) : 4'b0000;
    check_val("dec0", 32'(dec), 32'(exp_dec));
  endtask

  // Drive after the falling edge, model the rising edge, sample at the next falling edge.
  task automatic cycle(input logic r, input logic [3:0] q, input logic d);
    rst  = r;
    req  = q;
    done = d;
    @(posedge clk);
    model_step(r, q, d);
    @(negedge clk);
    compare_all();
  endtask

  logic [1:0] seq [$];
  logic [1:0] prev;
  logic [3:0] rq;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    req   = 4'd0;
    done  = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset with everyone requesting, then first grant goes to requester 0.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 4'hF, 1'b0);
      check_val("rst_valid", 32'(d_valid[0]), 32'd0);
      check_val("rst_idx",   32'(d_idx[0]),   32'd0);
      check_val("rst_to",    32'(d_to[0]),    32'd0);
    end
    cycle(1'b0, 4'hF, 1'b0);
    check_val("first_valid", 32'(d_valid[0]), 32'd1);
    check_val("first_idx",   32'(d_idx[0]),   32'd0);

    // Rotation with done every third cycle, no valid gaps.
    seq.delete();
    prev = d_idx[0];
    seq.push_back(prev);
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b0, 4'hF, (k % 3) == 0);
      check_val("rot_valid", 32'(d_valid[0]), 32'd1);
      if (d_idx[0] != prev) begin
        prev = d_idx[0];
        seq.push_back(prev);
      end
    end
    check_val("rot_len", 32'(seq.size()), 32'd5);
    for (int i = 0; i < seq.size(); i++)
      check_val($sformatf("rot_seq%0d", i), 32'(seq[i]), 32'(i % 4));

    // Hold-limit timeout on the MAX_HOLD=4 instance.
    cycle(1'b1, 4'b0101, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      cycle(1'b0, 4'b0101, 1'b0);
      check_val("tmo_idx", 32'(d_idx[1]), (c <= 4 || c == 9) ? 32'd0 : 32'd2);
      check_val("tmo_pulse", 32'(d_to[1]), (c == 5 || c == 9) ? 32'd1 : 32'd0);
    end

    // Owner withdraws, then is re-granted as sole requester.
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0010, 1'b0);
    check_val("wd_grant_idx", 32'(d_idx[0]), 32'd1);
    cycle(1'b0, 4'b0000, 1'b0);
    check_val("wd_idle", 32'(d_valid[0]), 32'd0);
    cycle(1'b0, 4'b0010, 1'b0);
    check_val("wd_regrant_valid", 32'(d_valid[0]), 32'd1);
    check_val("wd_regrant_idx",   32'(d_idx[0]),   32'd1);

    // done on the same edge as the hold limit (MAX_HOLD=2) wins over timeout.
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0011, 1'b0);
    check_val("sim_idx_a", 32'(d_idx[2]), 32'd0);
    cycle(1'b0, 4'b0011, 1'b0);
    check_val("sim_to_a",  32'(d_to[2]),  32'd0);
    cycle(1'b0, 4'b0011, 1'b1);
    check_val("sim_to_b",  32'(d_to[2]),  32'd0);
    check_val("sim_idx_b", 32'(d_idx[2]), 32'd1);
    cycle(1'b0, 4'b0000, 1'b0);
    check_val("sim_to_c",  32'(d_to[2]),  32'd0);

    // Reset mid-grant restarts the search at requester 0.
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0100, 1'b0);
    check_val("mid_idx", 32'(d_idx[0]), 32'd2);
    cycle(1'b1, 4'b0100, 1'b0);
    check_val("mid_rst_valid", 32'(d_valid[0]), 32'd0);
    check_val("mid_rst_idx",   32'(d_idx[0]),   32'd0);
    cycle(1'b0, 4'b1100, 1'b0);
    check_val("mid_post_valid", 32'(d_valid[0]), 32'd1);
    check_val("mid_post_idx",   32'(d_idx[0]),   32'd2);

    // Random traffic: sticky requests, done rate varied so long holds also occur.
    rq = 4'hF;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 3) rq = 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 79) == 0, rq,
            (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_grant_enc4.md
Name: rr_grant_enc4

Overview:
- 4-requester round-robin arbiter that produces a registered 2-bit grant index plus valid. It sits directly upstream of the 2-to-4 decoder stage.
- The decoder turns gnt_idx into the one-hot grant/enable bus. This block owns fairness, grant hold and release, and the timeout.
- Output is binary-encoded by design, so exactly one requester is ever selected downstream.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release; legal range 1..256.
- CNT_W, $clog2(MAX_HOLD+1), hold-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req  input  4  request vector; bit i = requester i wants the resource.
- done  input  1  current owner releases the grant this cycle.
- gnt_idx  output  2  index of the granted requester; feeds decoder input a.
- gnt_valid  output  1  gnt_idx is a live grant; the downstream decoder output is qualified by this.
- timeout  output  1  one-cycle pulse: the grant was force-released by the hold limit.
- busy  output  1  equals gnt_valid; provided for status logic.

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-high, sampled on the clk rising edge. rst has priority over every other input.
- Reset values:
  - state=IDLE, gnt_valid=0, gnt_idx=2'd0, timeout=0, busy=0, hold_cnt=0.
  - last=2'd3, so the first search order is 0,1,2,3.
- All outputs are registered; none combinational from inputs.
- Search order: starting at last+1 and wrapping modulo 4, the first set bit of req wins. The previous owner is always lowest priority.
- IDLE:
  - req==0 -> stay IDLE, gnt_valid=0.
  - req!=0 at edge N -> GRANT. gnt_idx=winner and gnt_valid=1 from edge N (visible cycle N+1). hold_cnt=0.
  - Request-to-grant latency is 1 clock.
- GRANT: gnt_idx held stable; hold_cnt increments each cycle, saturating at MAX_HOLD. A release condition is evaluated each edge:
  - (a) done=1;
  - (b) req[gnt_idx]=0 (owner withdrew);
  - (c) hold_cnt==MAX_HOLD-1 with neither (a) nor (b) true, which sets timeout=1 for exactly one cycle.
- On release at edge M:
  - last<=gnt_idx.
  - If any req bit is set, re-arbitrate in the same edge using the new last. The new gnt_idx is valid cycle M+1 with no idle bubble, and hold_cnt=0.
  - Otherwise go to IDLE with gnt_valid=0.
  - The releasing owner may be re-granted only if it is the sole requester.
- Simultaneous events:
  - done and timeout condition on the same edge -> treated as done; timeout stays 0.
  - done with req==0 -> IDLE.
- New requests arriving mid-grant never pre-empt the owner.
- MAX_HOLD=1: every grant lasts exactly one cycle, timeout pulses each cycle unless done/withdraw, and arbitration rotates every cycle.
- rst asserted mid-grant: the next edge returns all reset values and last=3, regardless of req/done.
- timeout is 0 in every cycle other than the forced-release pulse.

Decomposition:
- Package rr_grant_pkg holds:
  - NREQ=4 and IDX_W=2;
  - the state enum {IDLE, GRANT} as a 1-bit typedef;
  - typedef idx_t logic [IDX_W-1:0].
- Sub-module rr_pick4 (combinational): inputs req[3:0], last[1:0]; outputs idx[1:0], any. It implements the rotate/priority search and is instanced once for both the IDLE and re-arbitration paths.
- Top holds the FSM, hold counter, last register and output registers.

Test Plan:
1. Reset and first grant: rst=1 for 2 cycles with req=4'b1111 -> gnt_valid=0, gnt_idx=0, timeout=0 during reset. Release rst -> one edge later gnt_valid=1, gnt_idx=0.
2. Rotation: req=4'b1111 held, done=1 every 3rd cycle -> gnt_idx sequence 0,1,2,3,0 with no gnt_valid gap between grants.
3. Timeout: MAX_HOLD=4, req=4'b0101, done=0 -> gnt_idx=0 for 4 cycles, timeout=1 for one cycle at release, then gnt_idx=2. Same 4-cycle timeout seen again on the switch back to 0.
4. Withdraw and sole requester: owner 1 drops req (req 4'b0010 -> 4'b0000) -> next edge gnt_valid=0, IDLE. Then req=4'b0010 again -> gnt_idx=1 re-granted after 1 cycle.
5. Simultaneous done+timeout: MAX_HOLD=2, done=1 on the edge hold_cnt==1 -> release with timeout=0 throughout.
6. Reset mid-grant: gnt_idx=2 active, assert rst one cycle -> gnt_valid=0, gnt_idx=0. With req=4'b1100 after reset release, gnt_idx=2 (search restarts at 0). The bench also drives gnt_idx/gnt_valid into the 2-to-4 decoder and checks that the one-hot output equals 4'b0001<<gnt_idx whenever gnt_valid=1.
